joker_cmd_dispatch: RTL and testbench
=====================================

JOKER_CMD_DISPATCH -- requirements
Module: joker_cmd_dispatch

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 24'd12000000, meaning max cycles to wait for sub-block ack (~100 ms at 120 MHz).
REQ-002 SHALL have parameter CMD_MAX, default 8'h3F, meaning highest valid command code; codes 1..CMD_MAX are valid.
REQ-003 clk  input  1  system clock; all logic on posedge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 buf_out_hasdata  input  1  EP2 OUT buffer holds a received packet.
REQ-006 buf_out_len  input  10  EP2 OUT packet length in bytes.
REQ-007 buf_out_q  input  8  EP2 OUT RAM read data, valid 2 cycles after address.
REQ-008 disp_addr  output  11  EP2 OUT read address while dispatcher owns the buffer.
REQ-009 addr_own  output  1  high = disp_addr drives buf_out_addr; low = active sub-block drives it.
REQ-010 buf_out_arm  output  1  request to re-arm EP2 OUT; held until buf_out_arm_ack.
REQ-011 buf_out_arm_ack  input  1  EP2 OUT re-arm acknowledged.
REQ-012 j_cmd  output  8  active command to sub-blocks; 0 = none.
REQ-013 sub_ack  input  1  OR of sub-block ack_o lines.
REQ-014 sub_commit_len  input  11  IN length produced by active sub-block, valid while sub_ack high.
REQ-015 usb_in_ready  input  1  EP1 IN buffer free for commit.
REQ-016 usb_in_commit  output  1  EP1 IN commit request; held until usb_in_commit_ack.
REQ-017 usb_in_commit_ack  input  1  EP1 IN commit accepted.
REQ-018 usb_in_commit_len  output  11  committed IN length.
REQ-019 err_code  output  2  last error: 0 none, 1 empty packet, 2 bad command, 3 timeout.
REQ-020 err_cnt  output  8  saturating error counter.

Function
REQ-021 States SHALL be: ARM, IDLE, FETCH, DECODE, DISPATCH, RELEASE, COMMIT, COMMIT_WAIT.
REQ-022 IDLE: addr_own=1, disp_addr=0, j_cmd=0; on buf_out_hasdata=1 -> FETCH, load wait counter 0.
REQ-023 FETCH SHALL wait exactly 2 cycles (RAM latency) then register buf_out_q as cmd and -> DECODE.
REQ-024 DECODE: buf_out_len==0 -> err_code=1, ARM; cmd==0 or cmd>CMD_MAX -> err_code=2, ARM; else -> DISPATCH.
REQ-025 DISPATCH: j_cmd=cmd, addr_own=0, timeout counter increments each cycle; on sub_ack=1 latch sub_commit_len into usb_in_commit_len, set j_cmd=0, -> RELEASE.
REQ-026 DISPATCH timeout: counter reaching TIMEOUT_CYCLES-1 without sub_ack -> j_cmd=0, err_code=3, -> ARM (no IN commit).
REQ-027 RELEASE: wait sub_ack=0; then commit len 0 -> ARM, else -> COMMIT.
REQ-028 COMMIT: addr_own=1; wait usb_in_ready=1, then assert usb_in_commit, -> COMMIT_WAIT.
REQ-029 COMMIT_WAIT: hold usb_in_commit until usb_in_commit_ack=1, deassert same edge, -> ARM.
REQ-030 ARM: assert buf_out_arm until buf_out_arm_ack=1, deassert same edge, -> IDLE.
REQ-031 Each error SHALL increment err_cnt, saturating at 8'hFF; err_code holds until next error.
REQ-032 j_cmd SHALL be nonzero only in DISPATCH; addr_own SHALL be 0 only in DISPATCH and RELEASE.
REQ-033 buf_out_hasdata dropping while not IDLE SHALL be ignored; packet processed to completion.
REQ-034 sub_ack already high on DISPATCH entry SHALL be accepted on that cycle.
REQ-035 usb_in_commit and buf_out_arm SHALL never be high simultaneously.

Reset
REQ-036 On reset: j_cmd=0, usb_in_commit=0, usb_in_commit_len=0, buf_out_arm=0, disp_addr=0, addr_own=1, err_code=0, err_cnt=0, counters 0, state ARM.
REQ-037 Reset mid-DISPATCH SHALL drop j_cmd to 0 next edge; first post-reset action SHALL be one EP2 OUT arm.

Verification
REQ-038 Reset release -> buf_out_arm=1 until arm_ack, then IDLE, all other outputs 0.
REQ-039 Packet len=5, byte0=0x01, sub_ack after 20 cycles with sub_commit_len=4 -> j_cmd=0x01 from cycle 4 after hasdata, usb_in_commit_len=4, commit then arm.
REQ-040 Packet byte0=0x00, then byte0=0x80 -> no j_cmd, err_code=2, err_cnt=2, two arms, no commit.
REQ-041 Valid cmd, sub_ack never -> j_cmd cleared after TIMEOUT_CYCLES (bench override 100), err_code=3, arm, no commit.
REQ-042 sub_commit_len=0 -> no usb_in_commit, direct arm; usb_in_ready low 50 cycles with len=8 -> commit waits, asserts cycle after ready.
REQ-043 Reset asserted during DISPATCH -> j_cmd=0 next edge, state ARM, err_cnt=0.

Source files
------------

// File: rtl/joker_cmd_dispatch.sv
// EP2 OUT command dispatcher: fetches the command byte of each received packet,
// hands it to the sub-blocks, commits their EP1 IN reply and re-arms EP2 OUT.
module joker_cmd_dispatch #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd12000000,
  parameter logic [7:0]  CMD_MAX        = 8'h3F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        buf_out_hasdata,
  input  logic [9:0]  buf_out_len,
  input  logic [7:0]  buf_out_q,
  output logic [10:0] disp_addr,
  output logic        addr_own,
  output logic        buf_out_arm,
  input  logic        buf_out_arm_ack,
  output logic [7:0]  j_cmd,
  input  logic        sub_ack,
  input  logic [10:0] sub_commit_len,
  input  logic        usb_in_ready,
  output logic        usb_in_commit,
  input  logic        usb_in_commit_ack,
  output logic [10:0] usb_in_commit_len,
  output logic [1:0]  err_code,
  output logic [7:0]  err_cnt
);

  typedef enum logic [2:0] {
    ST_ARM, ST_IDLE, ST_FETCH, ST_DECODE, ST_DISPATCH, ST_RELEASE, ST_COMMIT, ST_COMMIT_WAIT
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE, ERR_EMPTY, ERR_BAD_CMD, ERR_TIMEOUT
  } err_e;

  state_t      state, state_d;
  logic [23:0] cnt, cnt_d;
  logic [7:0]  cmd, cmd_d;
  logic [10:0] commit_len_d;
  logic        err_set;
  err_e        err_val;
  logic [7:0]  j_cmd_d;
  logic        addr_own_d, arm_d, commit_d;

  // Only the command byte at offset 0 is ever read by the dispatcher.
  assign disp_addr = 11'd0;

  // State and registered outputs. Outputs are computed from the next state so
  // they change on the same edge as the state and are all quiet while in reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= ST_ARM;
      cnt               <= '0;
      cmd               <= '0;
      j_cmd             <= '0;
      addr_own          <= 1'b1;
      buf_out_arm       <= 1'b0;
      usb_in_commit     <= 1'b0;
      usb_in_commit_len <= '0;
      err_code          <= '0;
      err_cnt           <= '0;
    end else begin
      state             <= state_d;
      cnt               <= cnt_d;
      cmd               <= cmd_d;
      j_cmd             <= j_cmd_d;
      addr_own          <= addr_own_d;
      buf_out_arm       <= arm_d;
      usb_in_commit     <= commit_d;
      usb_in_commit_len <= commit_len_d;
      if (err_set) begin
        err_code <= err_val;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    state_d      = state;
    cnt_d        = cnt;
    cmd_d        = cmd;
    commit_len_d = usb_in_commit_len;
    err_set      = 1'b0;
    err_val      = ERR_NONE;
    case (state)
      ST_ARM: begin
        if (buf_out_arm && buf_out_arm_ack) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (buf_out_hasdata) begin
          state_d = ST_FETCH;
          cnt_d   = '0;
        end
      end
      ST_FETCH: begin
        // Address 0 has been on the bus since IDLE; two cycles cover RAM latency.
        if (cnt == 24'd1) begin
          cmd_d   = buf_out_q;
          state_d = ST_DECODE;
        end else begin
          cnt_d = cnt + 24'd1;
        end
      end
      ST_DECODE: begin
        if (buf_out_len == 10'd0) begin
          err_set = 1'b1;
          err_val = ERR_EMPTY;
          state_d = ST_ARM;
        end else if (cmd == 8'd0 || cmd > CMD_MAX) begin
          err_set = 1'b1;
          err_val = ERR_BAD_CMD;
          state_d = ST_ARM;
        end else begin
          cnt_d   = '0;
          state_d = ST_DISPATCH;
        end
      end
      ST_DISPATCH: begin
        if (sub_ack) begin
          commit_len_d = sub_commit_len;
          state_d      = ST_RELEASE;
        end else if (cnt == TIMEOUT_CYCLES - 24'd1) begin
          err_set = 1'b1;
          err_val = ERR_TIMEOUT;
          state_d = ST_ARM;
        end else begin
          cnt_d = cnt + 24'd1;
        end
      end
      ST_RELEASE: begin
        if (!sub_ack) state_d = (usb_in_commit_len == 11'd0) ? ST_ARM : ST_COMMIT;
      end
      ST_COMMIT: begin
        if (usb_in_ready) state_d = ST_COMMIT_WAIT;
      end
      ST_COMMIT_WAIT: begin
        if (usb_in_commit_ack) state_d = ST_ARM;
      end
      default: state_d = ST_ARM;
    endcase
  end

  // Output decode of the upcoming state.
  always_comb begin
    j_cmd_d    = (state_d == ST_DISPATCH) ? cmd_d : 8'd0;
    addr_own_d = !(state_d == ST_DISPATCH || state_d == ST_RELEASE);
    arm_d      = (state_d == ST_ARM);
    commit_d   = (state_d == ST_COMMIT_WAIT);
  end

endmodule

// File: tb/tb_joker_cmd_dispatch.sv
// Bench for joker_cmd_dispatch: models EP2 OUT RAM, sub-block and EP1 IN handshakes;
// DUT events (command issue, IN commit, error) are matched against a queue of expectations.
module tb_joker_cmd_dispatch;

  localparam logic [23:0] TMO = 24'd100;

  logic        clk = 1'b0;
  logic        reset;
  logic        buf_out_hasdata;
  logic [9:0]  buf_out_len;
  logic [7:0]  buf_out_q;
  logic [10:0] disp_addr;
  logic        addr_own;
  logic        buf_out_arm;
  logic        buf_out_arm_ack;
  logic [7:0]  j_cmd;
  logic        sub_ack;
  logic [10:0] sub_commit_len;
  logic        usb_in_ready;
  logic        usb_in_commit;
  logic        usb_in_commit_ack;
  logic [10:0] usb_in_commit_len;
  logic [1:0]  err_code;
  logic [7:0]  err_cnt;

  joker_cmd_dispatch #(.TIMEOUT_CYCLES(TMO), .CMD_MAX(8'h3F)) dut (
    .clk(clk), .reset(reset),
    .buf_out_hasdata(buf_out_hasdata), .buf_out_len(buf_out_len), .buf_out_q(buf_out_q),
    .disp_addr(disp_addr), .addr_own(addr_own),
    .buf_out_arm(buf_out_arm), .buf_out_arm_ack(buf_out_arm_ack),
    .j_cmd(j_cmd), .sub_ack(sub_ack), .sub_commit_len(sub_commit_len),
    .usb_in_ready(usb_in_ready), .usb_in_commit(usb_in_commit),
    .usb_in_commit_ack(usb_in_commit_ack), .usb_in_commit_len(usb_in_commit_len),
    .err_code(err_code), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // EP2 OUT RAM: byte 0 of the current packet, two-cycle read latency.
  logic [7:0] pkt_byte0 = 8'h00;
  logic [7:0] ram_rd1   = 8'h00;
  always @(posedge clk) begin
    ram_rd1   <= (disp_addr == 11'd0) ? pkt_byte0 : 8'hEE;
    buf_out_q <= ram_rd1;
  end

  typedef enum logic [1:0] {EV_NONE = 2'd0, EV_CMD = 2'd1, EV_COMMIT = 2'd2, EV_ERR = 2'd3} ev_e;
  typedef struct packed {
    ev_e         kind;
    logic [10:0] val;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   arm_cnt = 0, commit_cnt = 0, viol_excl = 0, viol_own = 0;
  logic [7:0] exp_err_cnt = 8'd0;
  logic [7:0] prev_j_cmd = 8'd0, prev_err_cnt = 8'd0;
  logic [1:0] prev_err_code = 2'd0;
  logic       prev_commit = 1'b0, prev_arm = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_ev(input ev_e k, input logic [10:0] v);
    exp_t e;
    e.kind = k;
    e.val  = v;
    sb.push_back(e);
  endtask

  // The counter saturates silently, so a saturated error produces no event.
  task automatic expect_err(input logic [1:0] code);
    if (exp_err_cnt != 8'hFF) begin
      expect_ev(EV_ERR, {9'd0, code});
      exp_err_cnt++;
    end
  endtask

  task automatic pop_cmp(input string tag, input ev_e k, input logic [10:0] v);
    exp_t got, e;
    got.kind = k;
    got.val  = v;
    if (sb.size() == 0) begin
      check({tag, "_unexpected"}, {19'd0, got}, 32'd0);
    end else begin
      e = sb.pop_front();
      check(tag, {19'd0, got}, {19'd0, e});
    end
  endtask

  // One clock: step to the falling edge, then observe DUT outputs.
  task automatic cyc();
    @(negedge clk);
    if (!reset) begin
      if (usb_in_commit && buf_out_arm) viol_excl++;
      if (j_cmd != 8'd0 && addr_own) viol_own++;
      if (j_cmd != 8'd0 && prev_j_cmd == 8'd0) pop_cmp("ev_cmd", EV_CMD, {3'd0, j_cmd});
      if (usb_in_commit && !prev_commit) begin
        commit_cnt++;
        pop_cmp("ev_commit", EV_COMMIT, usb_in_commit_len);
      end
      if (buf_out_arm && !prev_arm) arm_cnt++;
      if (err_cnt != prev_err_cnt || err_code != prev_err_code)
        pop_cmp("ev_err", EV_ERR, {9'd0, err_code});
    end
    prev_j_cmd    = j_cmd;
    prev_commit   = usb_in_commit;
    prev_arm      = buf_out_arm;
    prev_err_cnt  = err_cnt;
    prev_err_code = err_code;
  endtask

  task automatic start_pkt(input logic [7:0] b0, input logic [9:0] len);
    pkt_byte0       = b0;
    buf_out_len     = len;
    buf_out_hasdata = 1'b1;
  endtask

  task automatic wait_jcmd(input string tag, input int exp_n);
    int n = 0;
    while (j_cmd == 8'd0 && n < 40) begin
      cyc();
      n++;
    end
    check(tag, n, exp_n);
  endtask

  task automatic sub_respond(input int delay, input logic [10:0] clen, input logic [7:0] exp_cmd);
    repeat (delay) cyc();
    check("jcmd_held", j_cmd, exp_cmd);
    sub_ack        = 1'b1;
    sub_commit_len = clen;
    cyc();
    check("jcmd_clear_on_ack", j_cmd, 0);
    check("own_release", addr_own, 0);
    cyc();
    sub_ack        = 1'b0;
    sub_commit_len = 11'h7FF;
  endtask

  task automatic ack_commit();
    int n = 0;
    while (!usb_in_commit && n < 20) begin
      cyc();
      n++;
    end
    check("commit_seen", usb_in_commit, 1);
    cyc();
    check("commit_held", usb_in_commit, 1);
    usb_in_commit_ack = 1'b1;
    cyc();
    check("commit_drop", usb_in_commit, 0);
    usb_in_commit_ack = 1'b0;
  endtask

  task automatic do_arm();
    int n = 0;
    while (!buf_out_arm && n < 30) begin
      cyc();
      n++;
    end
    check("arm_seen", buf_out_arm, 1);
    buf_out_hasdata = 1'b0;
    cyc();
    check("arm_held", buf_out_arm, 1);
    buf_out_arm_ack = 1'b1;
    cyc();
    check("arm_drop", buf_out_arm, 0);
    buf_out_arm_ack = 1'b0;
    cyc();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a0, c0, early;
    reset = 1'b1;
    buf_out_hasdata = 1'b0; buf_out_len = '0; buf_out_arm_ack = 1'b0;
    sub_ack = 1'b0; sub_commit_len = '0; usb_in_ready = 1'b1; usb_in_commit_ack = 1'b0;
    repeat (3) cyc();
    check("rst_j_cmd", j_cmd, 0);
    check("rst_arm", buf_out_arm, 0);
    check("rst_commit", usb_in_commit, 0);
    check("rst_commit_len", usb_in_commit_len, 0);
    check("rst_addr_own", addr_own, 1);
    check("rst_disp_addr", disp_addr, 0);
    check("rst_err_code", err_code, 0);
    check("rst_err_cnt", err_cnt, 0);

    // Reset release: one arm, then idle.
    reset = 1'b0;
    cyc();
    check("arm_after_reset", buf_out_arm, 1);
    do_arm();
    check("arm_count_boot", arm_cnt, 1);
    check("idle_j_cmd", j_cmd, 0);
    check("idle_commit", usb_in_commit, 0);
    check("idle_addr_own", addr_own, 1);

    // Normal command: ack after 20 cycles, commit of 4 bytes, then arm.
    a0 = arm_cnt; c0 = commit_cnt;
    start_pkt(8'h01, 10'd5);
    expect_ev(EV_CMD, 11'h001);
    expect_ev(EV_COMMIT, 11'd4);
    wait_jcmd("jcmd_latency", 4);
    check("own_dispatch", addr_own, 0);
    sub_respond(20, 11'd4, 8'h01);
    ack_commit();
    check("commit_len", usb_in_commit_len, 4);
    do_arm();
    check("t1_arms", arm_cnt - a0, 1);
    check("t1_commits", commit_cnt - c0, 1);

    // Bad commands 0x00 and 0x80.
    a0 = arm_cnt; c0 = commit_cnt;
    start_pkt(8'h00, 10'd5);
    expect_err(2'd2);
    do_arm();
    start_pkt(8'h80, 10'd5);
    expect_err(2'd2);
    do_arm();
    check("t2_err_code", err_code, 2);
    check("t2_err_cnt", err_cnt, 2);
    check("t2_arms", arm_cnt - a0, 2);
    check("t2_commits", commit_cnt - c0, 0);

    // Boundaries: empty packet, first invalid code, highest valid code.
    start_pkt(8'h01, 10'd0);
    expect_err(2'd1);
    do_arm();
    check("empty_err_code", err_code, 1);
    start_pkt(8'h40, 10'd3);
    expect_err(2'd2);
    do_arm();
    // sub_ack already high at dispatch entry; hasdata drops mid-fetch.
    sub_ack = 1'b1; sub_commit_len = 11'd3;
    start_pkt(8'h3F, 10'd7);
    expect_ev(EV_CMD, 11'h03F);
    expect_ev(EV_COMMIT, 11'd3);
    cyc(); cyc();
    buf_out_hasdata = 1'b0;
    wait_jcmd("jcmd_latency_max", 2);
    cyc();
    check("jcmd_one_cycle", j_cmd, 0);
    sub_ack = 1'b0; sub_commit_len = 11'h7FF;
    ack_commit();
    check("commit_len_max", usb_in_commit_len, 3);
    do_arm();
    check("err_code_holds", err_code, 2);
    check("err_cnt_4", err_cnt, exp_err_cnt);

    // Timeout: sub-block never acks.
    a0 = arm_cnt; c0 = commit_cnt;
    start_pkt(8'h05, 10'd3);
    expect_ev(EV_CMD, 11'h005);
    expect_err(2'd3);
    wait_jcmd("jcmd_latency_tmo", 4);
    begin
      int n = 0;
      while (j_cmd != 8'd0 && n < 300) begin
        cyc();
        n++;
      end
      check("timeout_len", n, TMO);
    end
    check("tmo_err_code", err_code, 3);
    do_arm();
    check("tmo_arms", arm_cnt - a0, 1);
    check("tmo_commits", commit_cnt - c0, 0);

    // Zero-length reply: no commit, straight to arm.
    c0 = commit_cnt;
    start_pkt(8'h02, 10'd4);
    expect_ev(EV_CMD, 11'h002);
    wait_jcmd("jcmd_latency_zero", 4);
    sub_respond(3, 11'd0, 8'h02);
    do_arm();
    check("zero_len_commits", commit_cnt - c0, 0);

    // IN buffer busy for 50 cycles before an 8-byte commit.
    usb_in_ready = 1'b0;
    start_pkt(8'h03, 10'd9);
    expect_ev(EV_CMD, 11'h003);
    expect_ev(EV_COMMIT, 11'd8);
    wait_jcmd("jcmd_latency_busy", 4);
    sub_respond(5, 11'd8, 8'h03);
    early = 0;
    repeat (50) begin
      cyc();
      if (usb_in_commit) early++;
    end
    check("commit_waits_ready", early, 0);
    check("own_commit", addr_own, 1);
    usb_in_ready = 1'b1;
    cyc();
    check("commit_after_ready", usb_in_commit, 1);
    ack_commit();
    check("commit_len_busy", usb_in_commit_len, 8);
    do_arm();

    // Reset during dispatch.
    start_pkt(8'h04, 10'd2);
    expect_ev(EV_CMD, 11'h004);
    wait_jcmd("jcmd_latency_rst", 4);
    cyc(); cyc();
    reset = 1'b1; buf_out_hasdata = 1'b0;
    cyc();
    check("midrst_j_cmd", j_cmd, 0);
    check("midrst_err_cnt", err_cnt, 0);
    check("midrst_addr_own", addr_own, 1);
    check("midrst_arm", buf_out_arm, 0);
    exp_err_cnt = 8'd0;
    cyc();
    reset = 1'b0;
    a0 = arm_cnt; c0 = commit_cnt;
    do_arm();
    check("midrst_one_arm", arm_cnt - a0, 1);
    check("midrst_no_commit", commit_cnt - c0, 0);

    // Error counter saturation.
    for (int i = 0; i < 260; i++) begin
      start_pkt(8'h01, 10'd0);
      expect_err(2'd1);
      do_arm();
    end
    check("err_cnt_sat", err_cnt, 8'hFF);
    check("err_code_sat", err_code, 1);

    check("excl_arm_commit", viol_excl, 0);
    check("jcmd_addr_own", viol_own, 0);
    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
